pipe_wb_stage: RTL and testbench

Parametrised pipeline boundary register, successor to the single-channel MEM/WB latch. Carries NUM_CH independent write-back channels (address, enable, data) plus a valid bit across one pipeline stage. It adds:
- a flush input
- a configurable stall-vector stage index
- same-address write arbitration between channels
- register-0 write squashing

It sits between any two stages driven by the central stall controller, typically MEM->WB with NUM_CH=2 (GPR write plus HI/LO write).

---
 rtl/pipe_wb_stage.sv | 97 +++++++++
 tb/tb_pipe_wb_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_wb_stage.sv
// Multi-channel write-back pipeline register with flush, stall-vector control,
// same-address arbitration and register-0 squashing. Optional macro: PIPE_WB_PERF_EN.
module pipe_wb_stage #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int STALL_W     = 6,
    parameter int STAGE       = 4,
    parameter int ZERO_SQUASH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [STALL_W-1:0]       stall,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [NUM_CH*ADDR_W-1:0] in_wd,
    input  logic [NUM_CH-1:0]        in_wreg,
    input  logic [NUM_CH*DATA_W-1:0] in_wdata,
    output logic                     out_valid,
    output logic [NUM_CH*ADDR_W-1:0] out_wd,
    output logic [NUM_CH-1:0]        out_wreg,
    output logic [NUM_CH*DATA_W-1:0] out_wdata
`ifdef PIPE_WB_PERF_EN
    ,
    output logic [31:0]              bubble_cnt,
    output logic [31:0]              hold_cnt
`endif
);

    logic              stall_cur;
    logic              stall_next;
    logic              do_bubble;
    logic              do_hold;
    logic [NUM_CH-1:0] wreg_pre;
    logic [NUM_CH-1:0] wreg_arb;
    logic              unused_stall;

    assign stall_cur    = stall[STAGE];
    assign stall_next   = stall[STAGE+1];
    assign unused_stall = ^stall;

    // Flush dominates, so the bubble/hold decodes exclude it for the counters.
    assign do_bubble = !flush && stall_cur && !stall_next;
    assign do_hold   = !flush && stall_cur && stall_next;

    // Gate enables by valid and zero-address, then let the youngest channel win.
    always_comb begin
        wreg_pre = in_wreg & {NUM_CH{in_valid}};
        for (int k = 0; k < NUM_CH; k++) begin
            if ((ZERO_SQUASH != 0) && (in_wd[k*ADDR_W +: ADDR_W] == '0)) begin
                wreg_pre[k] = 1'b0;
            end
        end
        wreg_arb = wreg_pre;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = i + 1; j < NUM_CH; j++) begin
                if (wreg_pre[i] && wreg_pre[j] &&
                    (in_wd[i*ADDR_W +: ADDR_W] == in_wd[j*ADDR_W +: ADDR_W]) &&
                    (in_wd[i*ADDR_W +: ADDR_W] != '0)) begin
                    wreg_arb[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_wd    <= '0;
            out_wreg  <= '0;
            out_wdata <= '0;
        end else if (flush || do_bubble) begin
            out_valid <= 1'b0;
            out_wd    <= '0;
            out_wreg  <= '0;
            out_wdata <= '0;
        end else if (!stall_cur) begin
            out_valid <= in_valid;
            out_wd    <= in_wd;
            out_wreg  <= wreg_arb;
            out_wdata <= in_wdata;
        end
    end

`ifdef PIPE_WB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            if (do_bubble) bubble_cnt <= bubble_cnt + 32'd1;
            if (do_hold)   hold_cnt   <= hold_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Directed bench for pipe_wb_stage: one DUT with zero-squash on, one with it off.
module tb_pipe_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [9:0]  in_wd;
    logic [1:0]  in_wreg;
    logic [63:0] in_wdata;

    logic        out_valid,  nz_valid;
    logic [9:0]  out_wd,     nz_wd;
    logic [1:0]  out_wreg,   nz_wreg;
    logic [63:0] out_wdata,  nz_wdata;
`ifdef PIPE_WB_PERF_EN
    logic [31:0] bubble_cnt, hold_cnt, nz_bubble_cnt, nz_hold_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_wb_stage u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .out_valid(out_valid), .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata)
`ifdef PIPE_WB_PERF_EN
        , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
    );

    pipe_wb_stage #(.ZERO_SQUASH(0)) u_dut_nz (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .out_valid(nz_valid), .out_wd(nz_wd), .out_wreg(nz_wreg), .out_wdata(nz_wdata)
`ifdef PIPE_WB_PERF_EN
        , .bubble_cnt(nz_bubble_cnt), .hold_cnt(nz_hold_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'h0);
        chk({tag, ".wd"},    64'(out_wd),    64'h0);
        chk({tag, ".wreg"},  64'(out_wreg),  64'h0);
        chk({tag, ".wdata"}, out_wdata,      64'h0);
    endtask

    initial begin
        // 1. reset with live inputs, then first load
        rst      = 1'b0;
        stall    = 6'b000000;
        flush    = 1'b0;
        in_valid = 1'b1;
        in_wd    = {5'd3, 5'd7};
        in_wreg  = 2'b11;
        in_wdata = {32'hA, 32'hB};
        repeat (3) step();
        chk_bubble("rst");
        chk("rst.nz_wreg", 64'(nz_wreg), 64'h0);
`ifdef PIPE_WB_PERF_EN
        chk("rst.bubble_cnt", 64'(bubble_cnt), 64'h0);
        chk("rst.hold_cnt",   64'(hold_cnt),   64'h0);
`endif
        rst = 1'b1;
        step();
        chk("load1.valid", 64'(out_valid), 64'h1);
        chk("load1.wd",    64'(out_wd),    64'({5'd3, 5'd7}));
        chk("load1.wreg",  64'(out_wreg),  64'h3);
        chk("load1.wdata", out_wdata,      {32'hA, 32'hB});

        // 2. bubble then hold the bubble
        stall = 6'b010000;
        step();
        chk_bubble("bubble");
        stall = 6'b110000;
        for (int n = 0; n < 3; n++) begin
            step();
            chk_bubble("hold_bubble");
        end
`ifdef PIPE_WB_PERF_EN
        chk("t2.bubble_cnt", 64'(bubble_cnt), 64'd1);
        chk("t2.hold_cnt",   64'(hold_cnt),   64'd3);
`endif

        // 3. hold live content while inputs move
        stall    = 6'b000000;
        in_wd    = {5'd2, 5'd7};
        in_wreg  = 2'b01;
        in_wdata = {32'h0, 32'hDEAD};
        step();
        chk("load2.wreg",  64'(out_wreg), 64'h1);
        chk("load2.wdata", out_wdata,     {32'h0, 32'hDEAD});
        stall    = 6'b110000;
        in_wd    = {5'd1, 5'd1};
        in_wreg  = 2'b11;
        in_wdata = {32'h1, 32'h2};
        for (int n = 0; n < 2; n++) begin
            step();
            chk("hold.wdata", out_wdata,      {32'h0, 32'hDEAD});
            chk("hold.wreg",  64'(out_wreg),  64'h1);
            chk("hold.wd",    64'(out_wd),    64'({5'd2, 5'd7}));
            chk("hold.valid", 64'(out_valid), 64'h1);
        end

        // 4. flush beats hold
        flush = 1'b1;
        step();
        chk_bubble("flush");
`ifdef PIPE_WB_PERF_EN
        chk("t4.bubble_cnt", 64'(bubble_cnt), 64'd1);
        chk("t4.hold_cnt",   64'(hold_cnt),   64'd5);
`endif
        flush = 1'b0;

        // 5. same-address arbitration, zero squash, ignored stall bits
        stall    = 6'b000000;
        in_wd    = {5'd9, 5'd9};
        in_wreg  = 2'b11;
        in_wdata = {32'hC, 32'hD};
        step();
        chk("arb.wreg",    64'(out_wreg), 64'h2);
        chk("arb.nz_wreg", 64'(nz_wreg),  64'h2);
        stall = 6'b001111;
        in_wd = {5'd0, 5'd4};
        step();
        chk("squash.wreg",    64'(out_wreg),  64'h1);
        chk("squash.nz_wreg", 64'(nz_wreg),   64'h3);
        chk("squash.wd",      64'(out_wd),    64'({5'd0, 5'd4}));
        chk("squash.valid",   64'(out_valid), 64'h1);

        // 6. async reset in the middle of a hold, then invalid load
        stall = 6'b000000;
        in_wd = {5'd3, 5'd5};
        step();
        chk("load3.wreg", 64'(out_wreg), 64'h3);
        stall = 6'b110000;
        step();
        #2;
        rst = 1'b0;
        #1;
        chk_bubble("async_rst");
        chk("async_rst.nz_valid", 64'(nz_valid), 64'h0);
        step();
        rst      = 1'b1;
        stall    = 6'b000000;
        in_valid = 1'b0;
        in_wreg  = 2'b11;
        in_wdata = {32'hE, 32'hF};
        step();
        chk("inval.wreg",  64'(out_wreg),  64'h0);
        chk("inval.valid", 64'(out_valid), 64'h0);
        chk("inval.wd",    64'(out_wd),    64'({5'd3, 5'd5}));
        chk("inval.wdata", out_wdata,      {32'hE, 32'hF});
`ifdef PIPE_WB_PERF_EN
        chk("t6.bubble_cnt", 64'(bubble_cnt), 64'd0);
        chk("t6.hold_cnt",   64'(hold_cnt),   64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
